// File: rtl/vx_alu_dotp.sv
// vx_alu_dotp: pipelined packed-integer dot product with optional rs3 accumulate.
// Build option: define DOTP_INT4_EN to add the int4 element mode (op_mode[0]).
module vx_alu_dotp #(
    parameter int NUM_LANES = 1,
    parameter int XLEN      = 32,
    parameter int LATENCY   = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [2:0]                op_mode,
    input  logic [NUM_LANES*XLEN-1:0] rs1_data,
    input  logic [NUM_LANES*XLEN-1:0] rs2_data,
    input  logic [NUM_LANES*XLEN-1:0] rs3_data,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [NUM_LANES*XLEN-1:0] data_out,
    output logic [TAG_WIDTH-1:0]      tag_out
);

    localparam int DW = NUM_LANES * XLEN;
    localparam int N8 = XLEN / 8;

    // Products are widened to XLEN before summing; the full-precision
    // sum always fits, so the XLEN-wide total equals the extended sum.
    function automatic logic [XLEN-1:0] dot8(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic            uns
    );
        logic [XLEN-1:0]    acc;
        logic signed [8:0]  ea;
        logic signed [8:0]  eb;
        logic signed [17:0] p;
        acc = '0;
        for (int k = 0; k < N8; k++) begin
            ea  = {~uns & a[k*8+7], a[k*8 +: 8]};
            eb  = {~uns & b[k*8+7], b[k*8 +: 8]};
            p   = ea * eb;
            acc = acc + {{(XLEN-18){p[17]}}, p};
        end
        return acc;
    endfunction

`ifdef DOTP_INT4_EN
    localparam int N4 = XLEN / 4;

    function automatic logic [XLEN-1:0] dot4(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic            uns
    );
        logic [XLEN-1:0]   acc;
        logic signed [4:0] ea;
        logic signed [4:0] eb;
        logic signed [9:0] p;
        acc = '0;
        for (int k = 0; k < N4; k++) begin
            ea  = {~uns & a[k*4+3], a[k*4 +: 4]};
            eb  = {~uns & b[k*4+3], b[k*4 +: 4]};
            p   = ea * eb;
            acc = acc + {{(XLEN-10){p[9]}}, p};
        end
        return acc;
    endfunction
`endif

    // Per-lane add so a wrap in one lane never carries into the next.
    function automatic logic [DW-1:0] lane_add(
        input logic [DW-1:0] s,
        input logic [DW-1:0] a,
        input logic          use_acc
    );
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            r[i*XLEN +: XLEN] = s[i*XLEN +: XLEN]
                              + (use_acc ? a[i*XLEN +: XLEN] : '0);
        end
        return r;
    endfunction

    logic                 en;
    logic [DW-1:0]        sum_c;
    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   vld_d;
    logic [LATENCY-1:0]   acc_en_q;
    logic [LATENCY-1:0]   acc_en_d;
    logic [DW-1:0]        data_q [LATENCY];
    logic [DW-1:0]        data_d [LATENCY];
    logic [DW-1:0]        rs3_q  [LATENCY];
    logic [DW-1:0]        rs3_d  [LATENCY];
    logic [TAG_WIDTH-1:0] tag_q  [LATENCY];
    logic [TAG_WIDTH-1:0] tag_d  [LATENCY];
    logic                 unused_bits;

    assign en        = ready_out | ~valid_out;
    assign ready_in  = en;
    assign valid_out = vld_q[LATENCY-1];
    assign data_out  = data_q[LATENCY-1];
    assign tag_out   = tag_q[LATENCY-1];

`ifdef DOTP_INT4_EN
    assign unused_bits = ^{rs3_q[LATENCY-1], acc_en_q[LATENCY-1]};
`else
    assign unused_bits = ^{rs3_q[LATENCY-1], acc_en_q[LATENCY-1], op_mode[0]};
`endif

    // Per-lane extended dot-product sum of the incoming operands.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef DOTP_INT4_EN
            if (op_mode[0])
                sum_c[i*XLEN +: XLEN] = dot4(rs1_data[i*XLEN +: XLEN],
                                             rs2_data[i*XLEN +: XLEN],
                                             op_mode[1]);
            else
                sum_c[i*XLEN +: XLEN] = dot8(rs1_data[i*XLEN +: XLEN],
                                             rs2_data[i*XLEN +: XLEN],
                                             op_mode[1]);
`else
            sum_c[i*XLEN +: XLEN] = dot8(rs1_data[i*XLEN +: XLEN],
                                         rs2_data[i*XLEN +: XLEN],
                                         op_mode[1]);
`endif
        end
    end

    // Next contents of every stage; the last stage folds in rs3.
    always_comb begin
        vld_d[0]    = valid_in;
        acc_en_d[0] = op_mode[2];
        rs3_d[0]    = rs3_data;
        tag_d[0]    = tag_in;
        data_d[0]   = (LATENCY == 1)
                    ? lane_add(sum_c, rs3_data, op_mode[2])
                    : sum_c;
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s]    = vld_q[s-1];
            acc_en_d[s] = acc_en_q[s-1];
            rs3_d[s]    = rs3_q[s-1];
            tag_d[s]    = tag_q[s-1];
            data_d[s]   = (s == LATENCY - 1)
                        ? lane_add(data_q[s-1], rs3_q[s-1], acc_en_q[s-1])
                        : data_q[s-1];
        end
    end

    // Pipeline registers advance together under the global enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            acc_en_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
                rs3_q[s]  <= '0;
                tag_q[s]  <= '0;
            end
        end else if (en) begin
            vld_q    <= vld_d;
            acc_en_q <= acc_en_d;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= data_d[s];
                rs3_q[s]  <= rs3_d[s];
                tag_q[s]  <= tag_d[s];
            end
        end
    end

endmodule

// File: tb/tb_vx_alu_dotp.sv
// tb_vx_alu_dotp: directed scoreboard bench for vx_alu_dotp.
// Covers signed/unsigned/int4 modes, accumulate wrap, stalls and reset.
module tb_vx_alu_dotp;

    localparam int LAT = 2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        int          t_in;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [2:0]  op_mode;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic [7:0]  tag_in;
    logic        valid_out;
    logic        ready_out;
    logic [63:0] data_out;
    logic [7:0]  tag_out;

    logic        valid_in64;
    logic        ready_in64;
    logic [2:0]  op_mode64;
    logic [63:0] rs1_64;
    logic [63:0] rs3_64;
    logic        tag_in64;
    logic        valid_out64;
    logic        ready_out64;
    logic [63:0] data_out64;
    logic        tag_out64;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q32[$];

    vx_alu_dotp #(
        .NUM_LANES(2), .XLEN(32), .LATENCY(LAT), .TAG_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in), .op_mode(op_mode),
        .rs1_data(rs1), .rs2_data(rs2), .rs3_data(rs3), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .data_out(data_out), .tag_out(tag_out)
    );

    vx_alu_dotp #(
        .NUM_LANES(1), .XLEN(64), .LATENCY(LAT), .TAG_WIDTH(1)
    ) dut64 (
        .clk(clk), .reset(reset),
        .valid_in(valid_in64), .ready_in(ready_in64), .op_mode(op_mode64),
        .rs1_data(rs1_64), .rs2_data(rs1_64), .rs3_data(rs3_64),
        .tag_in(tag_in64),
        .valid_out(valid_out64), .ready_out(ready_out64),
        .data_out(data_out64), .tag_out(tag_out64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [2:0] m,
                        input logic [7:0] t, input logic [63:0] e,
                        input bit lat);
        int w;
        rs1 = a; rs2 = b; rs3 = c; op_mode = m; tag_in = t;
        valid_in = 1'b1;
        @(negedge clk);
        w = 0;
        while (!ready_in && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready_in)
            chk($sformatf("send_timeout_t%0d", t), 64'(ready_in), 64'(1));
        else
            q32.push_back('{data: e, tag: t, t_in: cyc, lat: lat});
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic send64(input logic [63:0] a, input logic [2:0] m,
                          input logic [63:0] e, input string name);
        @(posedge clk);
        #1;
        rs1_64 = a; op_mode64 = m; valid_in64 = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(ready_in64), 64'(1));
        @(posedge clk);
        #1 valid_in64 = 1'b0;
        @(negedge clk);
        chk({name, "_early"}, 64'(valid_out64), 64'(0));
        @(negedge clk);
        chk({name, "_valid"}, 64'(valid_out64), 64'(1));
        chk({name, "_data"}, data_out64, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output side of the scoreboard: pop on transfer, hold during stall.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid_out) begin
            if (q32.size() == 0) begin
                chk("unexpected_out", 64'(valid_out), 64'(0));
            end else if (ready_out) begin
                e = q32.pop_front();
                chk($sformatf("data_t%0d", e.tag), data_out, e.data);
                chk($sformatf("tag_t%0d", e.tag), 64'(tag_out), 64'(e.tag));
                if (e.lat)
                    chk($sformatf("latency_t%0d", e.tag),
                        64'(cyc - e.t_in), 64'(LAT));
            end else begin
                chk("stall_data", data_out, q32[0].data);
                chk("stall_tag", 64'(tag_out), 64'(q32[0].tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e3;
        logic [63:0] e64;
        int          w;
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        op_mode = '0; rs1 = '0; rs2 = '0; rs3 = '0; tag_in = '0;
        valid_in64 = 1'b0; ready_out64 = 1'b1; op_mode64 = '0;
        rs1_64 = '0; rs3_64 = '0; tag_in64 = 1'b0;
        #12;
        chk("rst_valid", 64'(valid_out), 64'(0));
        chk("rst_data", data_out, 64'(0));
        chk("rst_tag", 64'(tag_out), 64'(0));
        chk("rst_ready", 64'(ready_in), 64'(1));
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

`ifdef DOTP_INT4_EN
        e3 = {32'h0000_0002, 32'hFFFF_FFC0};
        e64 = 64'h40;
`else
        e3 = {32'h0000_0001, 32'hFFFF_E020};
        e64 = 64'h4000;
`endif
        send({32'h01010101, 32'h7F80FF01}, {32'h02020202, 32'h7F80FF01},
             64'h0, 3'b000, 8'd10, {32'h8, 32'h7F03}, 1'b1);
        send({32'hFFFFFFFF, 32'h7F80FF01}, {32'hFFFFFFFF, 32'h7F80FF01},
             64'h0, 3'b010, 8'd11, {32'h3F804, 32'h17D03}, 1'b1);
        send({32'h000000FF, 32'h88888888}, {32'h000000FF, 32'h11111111},
             64'h0, 3'b001, 8'd12, e3, 1'b1);
        send({2{32'h01010101}}, {2{32'h01010101}},
             {32'h00000100, 32'hFFFFFFFF}, 3'b100, 8'd13,
             {32'h104, 32'h3}, 1'b1);
        send({2{32'h01010101}}, {2{32'h01010101}},
             {32'h12345678, 32'h9ABCDEF0}, 3'b000, 8'd14,
             {32'h4, 32'h4}, 1'b1);
        send({2{32'h000000FF}}, {32'h2, 32'h1}, 64'h0, 3'b000, 8'd15,
             {32'hFFFFFFFE, 32'hFFFFFFFF}, 1'b1);
        send({2{32'h000000FF}}, {32'h2, 32'h1}, 64'h0, 3'b010, 8'd16,
             {32'h1FE, 32'hFF}, 1'b1);
        send({2{32'h000000FF}}, {32'h2, 32'h1}, {32'hFFFFFF00, 32'h5},
             3'b110, 8'd17, {32'hFE, 32'h104}, 1'b1);
        send({2{32'h000000FF}}, {32'h2, 32'h1}, {32'h5, 32'h1},
             3'b100, 8'd18, {32'h3, 32'h0}, 1'b1);
        idle(4);
        chk("directed_drain", 64'(q32.size()), 64'(0));

        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send({2{32'(k) * 32'h01010101}},
                         {2{32'(k) * 32'h01010101}}, 64'h0, 3'b000,
                         8'(k), {2{32'(4 * k * k)}}, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                @(posedge clk);
                #1 ready_out = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("ready_in_stall", 64'(ready_in), 64'(0));
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        w = 0;
        while (q32.size() != 0 && w < 50) begin
            idle(1);
            w++;
        end
        chk("stream_drain", 64'(q32.size()), 64'(0));

        idle(1);
        send({2{32'h01010101}}, {2{32'h01010101}}, 64'h0, 3'b000, 8'd20,
             {32'h4, 32'h4}, 1'b1);
        send({2{32'h02020202}}, {2{32'h01010101}}, 64'h0, 3'b000, 8'd21,
             {32'h8, 32'h8}, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(valid_out), 64'(0));
        chk("rst_mid_data", data_out, 64'(0));
        chk("rst_mid_tag", 64'(tag_out), 64'(0));
        q32.delete();
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", 64'(valid_out), 64'(0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(valid_out), 64'(0));
        end
        @(posedge clk);
        #1;
        send({2{32'h03030303}}, {2{32'h01010101}}, 64'h0, 3'b000, 8'd22,
             {32'hC, 32'hC}, 1'b1);
        idle(4);
        chk("post_rst_drain", 64'(q32.size()), 64'(0));

        send64(64'h0101010101010101, 3'b000, 64'h8, "x64_ones");
        send64(64'h7F00000000000000, 3'b000, 64'h3F01, "x64_top_s");
        send64(64'hFF00000000000000, 3'b010, 64'hFE01, "x64_top_u");
        send64(64'hFF00000000000000, 3'b000, 64'h1, "x64_neg_s");
        send64(64'h8000000000000000, 3'b001, e64, "x64_int4");
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
